// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. It adds DIGIT_WIDTH bits per clock, starting
// at the least-significant digit, and keeps the carry in a register between
// digits. Operands and results each use a valid/ready handshake.
// Optional build macro: SERIAL_ADDER_SUBTRACT_EN adds the Sub_In port, which
// selects A - B, computed as A + ~B + 1.
module serial_adder #(
    parameter int DATA_WIDTH  = 16,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic                  Sub_In,
`endif
    input  logic                  Start_Valid_In,
    output logic                  Start_Ready_Out,
    output logic                  Result_Valid_Out,
    input  logic                  Result_Ready_In,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Overflow_Out
);

    localparam int SAFE_DIGIT = (DIGIT_WIDTH < 1) ? 1 : DIGIT_WIDTH;
    localparam int N          = DATA_WIDTH / SAFE_DIGIT;
    localparam int K_W        = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    // Illegal width combinations stop elaboration.
    generate
        if ((DATA_WIDTH < 1) || (DIGIT_WIDTH < 1) || ((DATA_WIDTH % SAFE_DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: DIGIT_WIDTH must be >= 1 and divide DATA_WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    r_carry;
    logic [K_W-1:0]          r_k;
    logic [DATA_WIDTH-1:0]   r_sum;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_start_ready;
    logic                    r_result_valid;

    logic [DATA_WIDTH-1:0]   w_b_load;
    logic                    w_c_load;
    logic [DIGIT_WIDTH:0]    w_digit_sum;
    logic                    w_ovf;
    logic [DATA_WIDTH-1:0]   w_sum_next;

    // Select the operand B and initial carry that are latched on accept
    // (in subtract mode, B is inverted and the +1 enters as the carry).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_b_load = Data_B_In;
        w_c_load = Carry_In;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        if (Sub_In) begin
            w_b_load = ~Data_B_In;
            w_c_load = 1'b1;
        end
`endif
    end

    // One digit add. The operand registers shift right, so the current digit
    // is always in the low bits. The sum shifts in from the top, so after N
    // digits it is in place.
    always_comb begin
        w_digit_sum = {1'b0, r_a[DIGIT_WIDTH-1:0]}
                    + {1'b0, r_b[DIGIT_WIDTH-1:0]}
                    + {{DIGIT_WIDTH{1'b0}}, r_carry};
        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        w_ovf       = w_digit_sum[DIGIT_WIDTH]
                    ^ (w_digit_sum[DIGIT_WIDTH-1] ^ r_a[DIGIT_WIDTH-1] ^ r_b[DIGIT_WIDTH-1]);
        w_sum_next  = (r_sum >> DIGIT_WIDTH)
                    | (DATA_WIDTH'(w_digit_sum[DIGIT_WIDTH-1:0]) << (DATA_WIDTH - DIGIT_WIDTH));
    end

    // Control FSM with the datapath and all outputs registered.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        // NOTE: the internal registers are reset as well as the state, so an
        // aborted operation leaves nothing behind and the outputs start at 0.
        if (!Reset_n_In) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_carry        <= 1'b0;
            r_k            <= '0;
            r_sum          <= '0;
            r_cout         <= 1'b0;
            r_ovf          <= 1'b0;
            r_start_ready  <= 1'b1;
            r_result_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from the
            // values it had before the edge, whatever the statement order.
            case (r_state)
                IDLE: begin
                    if (Start_Valid_In && r_start_ready) begin
                        r_a           <= Data_A_In;
                        r_b           <= w_b_load;
                        r_carry       <= w_c_load;
                        r_k           <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> DIGIT_WIDTH;
                    r_b     <= r_b >> DIGIT_WIDTH;
                    r_carry <= w_digit_sum[DIGIT_WIDTH];
                    r_sum   <= w_sum_next;
                    r_k     <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_cout         <= w_digit_sum[DIGIT_WIDTH];
                        r_ovf          <= w_ovf;
                        r_result_valid <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    if (Result_Ready_In) begin
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign Start_Ready_Out  = r_start_ready;
    assign Result_Valid_Out = r_result_valid;
    assign Sum_Out          = r_sum;
    assign Carry_Out        = r_cout;
    assign Overflow_Out     = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (DATA_WIDTH=16, DIGIT_WIDTH=4).
// Uses a vector table plus hand-written sequences for backpressure and mid-op reset.
module tb_serial_adder;

    localparam int DW      = 16;
    localparam int GW      = 4;
    localparam int LATENCY = DW / GW;

    logic          Clock_In = 1'b0;
    logic          Reset_n_In;
    logic [DW-1:0] Data_A_In;
    logic [DW-1:0] Data_B_In;
    logic          Carry_In;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic          Sub_In;
`endif
    logic          Start_Valid_In;
    logic          Start_Ready_Out;
    logic          Result_Valid_Out;
    logic          Result_Ready_In;
    logic [DW-1:0] Sum_Out;
    logic          Carry_Out;
    logic          Overflow_Out;

    serial_adder #(.DATA_WIDTH(DW), .DIGIT_WIDTH(GW)) dut (
        .Clock_In         (Clock_In),
        .Reset_n_In       (Reset_n_In),
        .Data_A_In        (Data_A_In),
        .Data_B_In        (Data_B_In),
        .Carry_In         (Carry_In),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .Sub_In           (Sub_In),
`endif
        .Start_Valid_In   (Start_Valid_In),
        .Start_Ready_Out  (Start_Ready_Out),
        .Result_Valid_Out (Result_Valid_Out),
        .Result_Ready_In  (Result_Ready_In),
        .Sum_Out          (Sum_Out),
        .Carry_Out        (Carry_Out),
        .Overflow_Out     (Overflow_Out)
    );

    always #5 Clock_In = ~Clock_In;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        logic          sub;
        logic [DW-1:0] sum;
        logic          c;
        logic          v;
    } vec_t;

    typedef struct {
        logic [DW-1:0] sum;
        logic          c;
        logic          v;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: one full-width add, independent of the digit split.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [DW-1:0] bb;
        logic        ci;
        logic [DW:0] full;
        bb     = sub ? ~b : b;
        ci     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, ci};
        e.sum  = full[DW-1:0];
        e.c    = full[DW];
        e.v    = (a[DW-1] == bb[DW-1]) && (full[DW-1] != a[DW-1]);
        return e;
    endfunction

    task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic cin, input logic sub);
        Data_A_In      = a;
        Data_B_In      = b;
        Carry_In       = cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        Sub_In         = sub;
`else
        if (sub) $display("note: subtract vector driven in add-only build");
`endif
        Start_Valid_In = 1'b1;
    endtask

    // Wait (bounded) for ready, take the accept edge, and record the expected result.
    task automatic accept_op(input exp_t e);
        int t;
        t = 0;
        while (!Start_Ready_Out && t < 50) begin
            @(posedge Clock_In); #1;
            t++;
        end
        check("accept_ready", Start_Ready_Out, 1);
        @(posedge Clock_In);
        exp_q.push_back(e);
        #1;
        check("ready_low_after_accept", Start_Ready_Out, 0);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!Result_Valid_Out && lat < 50) begin
            @(posedge Clock_In); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LATENCY);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"},   Sum_Out,      e.sum);
            check({tag, "_carry"}, Carry_Out,    e.c);
            check({tag, "_ovf"},   Overflow_Out, e.v);
        end
    endtask

    task automatic handshake(input string tag);
        Result_Ready_In = 1'b1;
        @(posedge Clock_In); #1;
        Result_Ready_In = 1'b0;
        check({tag, "_valid_drop"}, Result_Valid_Out, 0);
        check({tag, "_ready_back"}, Start_Ready_Out,  1);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
        drive_op(a, b, cin, sub);
        accept_op(e);
        Start_Valid_In = 1'b0;
        wait_result(tag);
        compare_result(tag);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t          e;
        exp_t          snap;
        int            seen;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rc;
        logic          rs;

        vecs.push_back(vec_t'{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back(vec_t'{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back(vec_t'{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back(vec_t'{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back(vec_t'{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUBTRACT_EN
        vecs.push_back(vec_t'{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back(vec_t'{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back(vec_t'{16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1468, 1'b0, 1'b0});
        Sub_In = 1'b0;
`endif

        Reset_n_In      = 1'b0;
        Data_A_In       = '0;
        Data_B_In       = '0;
        Carry_In        = 1'b0;
        Start_Valid_In  = 1'b0;
        Result_Ready_In = 1'b0;
        repeat (3) @(posedge Clock_In);
        #1;
        Reset_n_In = 1'b1;
        check("reset_start_ready",  Start_Ready_Out,  1);
        check("reset_result_valid", Result_Valid_Out, 0);
        check("reset_sum",          Sum_Out,          0);
        check("reset_carry",        Carry_Out,        0);
        check("reset_ovf",          Overflow_Out,     0);

        // Table vectors.
        foreach (vecs[i]) begin
            e.sum = vecs[i].sum;
            e.c   = vecs[i].c;
            e.v   = vecs[i].v;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
        end

        // Random vectors, checked against the full-width model.
        for (int i = 0; i < 6; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUBTRACT_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        // Backpressure: Start_Valid held high; the result is held for 5 cycles.
        drive_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        e.sum = 16'h1000; e.c = 1'b0; e.v = 1'b0;
        accept_op(e);
        drive_op(16'h0003, 16'h0004, 1'b0, 1'b0);   // next op waits, valid stays high
        wait_result("bp");
        snap.sum = Sum_Out; snap.c = Carry_Out; snap.v = Overflow_Out;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock_In); #1;
            check("bp_hold_valid", Result_Valid_Out, 1);
            check("bp_hold_ready", Start_Ready_Out,  0);
            check("bp_hold_sum",   Sum_Out,          snap.sum);
            check("bp_hold_carry", Carry_Out,        snap.c);
            check("bp_hold_ovf",   Overflow_Out,     snap.v);
        end
        compare_result("bp");
        handshake("bp");
        @(posedge Clock_In);
        e.sum = 16'h0007; e.c = 1'b0; e.v = 1'b0;
        exp_q.push_back(e);
        #1;
        check("bp_next_accepted", Start_Ready_Out, 0);
        Start_Valid_In = 1'b0;
        wait_result("bp_next");
        compare_result("bp_next");
        handshake("bp_next");

        // Reset during the 2nd BUSY cycle: operation discarded.
        drive_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
        seen = 0;
        while (!Start_Ready_Out && seen < 50) begin
            @(posedge Clock_In); #1;
            seen++;
        end
        @(posedge Clock_In); #1;      // accept edge
        Start_Valid_In = 1'b0;
        @(posedge Clock_In); #1;      // now in the 2nd BUSY cycle
        check("pre_reset_busy", Start_Ready_Out, 0);
        Reset_n_In = 1'b0;
        #1;
        check("mid_reset_start_ready",  Start_Ready_Out,  1);
        check("mid_reset_result_valid", Result_Valid_Out, 0);
        check("mid_reset_sum",          Sum_Out,          0);
        check("mid_reset_carry",        Carry_Out,        0);
        check("mid_reset_ovf",          Overflow_Out,     0);
        #2;
        Reset_n_In = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock_In); #1;
            if (Result_Valid_Out) seen++;
        end
        check("no_valid_after_reset", seen, 0);
        e.sum = 16'h0002; e.c = 1'b0; e.v = 1'b0;
        run_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, e);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
